// File: rtl/chess_board_state.sv
// Authoritative 64-square board register with side-to-move bit.
// Accepts moves via valid/ready, checks ownership, commits atomically.
module chess_board_state (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         new_game,
  input  logic         move_valid,
  output logic         move_ready,
  input  logic [5:0]   move_from,
  input  logic [5:0]   move_to,
  output logic         done,
  output logic         move_err,
  output logic [3:0]   captured,
  output logic [255:0] boardData,
  output logic         turn
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    COMMIT,
    RESP
  } state_t;

  function automatic logic [3:0] start_sq(
    input logic [5:0] i
  );
    logic [3:0] back;
    unique case (i[2:0])
      3'd0, 3'd7: back = 4'h4;
      3'd1, 3'd6: back = 4'h2;
      3'd2, 3'd5: back = 4'h3;
      3'd3:       back = 4'h5;
      3'd4:       back = 4'h6;
    endcase
    unique case (i[5:3])
      3'd0:    return back;
      3'd1:    return 4'h1;
      3'd6:    return 4'h9;
      3'd7:    return {1'b1, back[2:0]};
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [63:0][3:0] start_board();
    logic [63:0][3:0] b;
    for (int i = 0; i < 64; i++)
      b[i] = start_sq(6'(i));
    return b;
  endfunction

  localparam logic [63:0][3:0] START = start_board();

  state_t           state, state_n;
  logic [63:0][3:0] board_q;
  logic [5:0]       from_q, to_q;
  logic [3:0]       src, dst, piece;
  logic             rej, err_q, accept;

  assign boardData  = board_q;
  assign src        = board_q[from_q];
  assign dst        = board_q[to_q];
  assign move_ready = (state == IDLE) && !new_game;
  assign accept     = move_valid && move_ready;

  always_comb begin
    rej = (src[2:0] == 3'd0)
       || (src[3] != turn)
       || (from_q == to_q)
       || ((dst != 4'h0) && (dst[3] == src[3]));
  end

  // Pawns reaching the far rank become queens of the same colour.
  always_comb begin
    piece = src;
    unique case (1'b1)
      (src == 4'h1 && to_q[5:3] == 3'd7):
        piece = 4'h5;
      (src == 4'h9 && to_q[5:3] == 3'd0):
        piece = 4'hD;
      default: piece = src;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (accept) state_n = CHECK;
      CHECK:  state_n = COMMIT;
      COMMIT: state_n = RESP;
      RESP:   state_n = IDLE;
    endcase
    if (new_game) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      board_q  <= START;
      turn     <= 1'b0;
      from_q   <= '0;
      to_q     <= '0;
      err_q    <= 1'b0;
      done     <= 1'b0;
      move_err <= 1'b0;
      captured <= 4'h0;
    end else begin
      state <= state_n;
      done  <= 1'b0;
      if (new_game) begin
        board_q <= START;
        turn    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (accept) begin
            from_q <= move_from;
            to_q   <= move_to;
          end
          CHECK: err_q <= rej;
          COMMIT: begin
            done     <= 1'b1;
            move_err <= err_q;
            captured <= err_q ? 4'h0 : dst;
            if (!err_q) begin
              board_q[to_q]   <= piece;
              board_q[from_q] <= 4'h0;
              turn            <= ~turn;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chess_board_state.sv
// Bench for chess_board_state: square-array model of the game rules
// checked every cycle, plus literal expectations for key squares.
module tb_chess_board_state;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         new_game;
  logic         move_valid;
  logic         move_ready;
  logic [5:0]   move_from;
  logic [5:0]   move_to;
  logic         done;
  logic         move_err;
  logic [3:0]   captured;
  logic [255:0] boardData;
  logic         turn;

  chess_board_state dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .new_game   (new_game),
    .move_valid (move_valid),
    .move_ready (move_ready),
    .move_from  (move_from),
    .move_to    (move_to),
    .done       (done),
    .move_err   (move_err),
    .captured   (captured),
    .boardData  (boardData),
    .turn       (turn)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [3:0] mb [64];
  logic       mturn;
  logic       exp_ready, exp_done, exp_err;
  logic [3:0] exp_cap;
  logic       chk_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [255:0] a,
                     input logic [255:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, a, e, $time);
    end
  endtask

  task automatic reset_model();
    logic [3:0] back [8];
    back = '{4'h4, 4'h2, 4'h3, 4'h5,
             4'h6, 4'h3, 4'h2, 4'h4};
    for (int i = 0; i < 64; i++) mb[i] = 4'h0;
    for (int f = 0; f < 8; f++) begin
      mb[f]      = back[f];
      mb[8 + f]  = 4'h1;
      mb[48 + f] = 4'h9;
      mb[56 + f] = back[f] | 4'h8;
    end
    mturn = 1'b0;
  endtask

  task automatic apply_model(input int f, input int t);
    logic [3:0] s, d, p;
    logic       bad_mv;
    s = mb[f];
    d = mb[t];
    bad_mv = (s % 8 == 0) || ((s / 8) != mturn)
          || (f == t) || (d != 0 && (d / 8) == (s / 8));
    exp_err = bad_mv;
    exp_cap = 4'h0;
    if (!bad_mv) begin
      p = s;
      if (s == 4'h1 && t / 8 == 7) p = 4'h5;
      if (s == 4'h9 && t / 8 == 0) p = 4'hD;
      mb[t]   = p;
      mb[f]   = 4'h0;
      mturn   = ~mturn;
      exp_cap = d;
    end
  endtask

  always @(negedge clk) begin
    logic [255:0] eb;
    if (chk_en) begin
      for (int i = 0; i < 64; i++) eb[i*4 +: 4] = mb[i];
      chk("board", boardData, eb);
      chk("turn", turn, mturn);
      chk("ready", move_ready, exp_ready);
      chk("done", done, exp_done);
      chk("err", move_err, exp_err);
      chk("cap", captured, exp_cap);
    end
  end

  task automatic mv(input int f, input int t);
    @(posedge clk); #1;
    move_valid = 1'b1;
    move_from  = 6'(f);
    move_to    = 6'(t);
    @(posedge clk); #1;
    move_valid = 1'b0;
    exp_ready  = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    apply_model(f, t);
    exp_done = 1'b1;
    @(posedge clk); #1;
    exp_done  = 1'b0;
    exp_ready = 1'b1;
  endtask

  function automatic logic [3:0] sq(input int i);
    return boardData[i*4 +: 4];
  endfunction

  initial begin
    rst_n      = 1'b0;
    new_game   = 1'b0;
    move_valid = 1'b0;
    move_from  = '0;
    move_to    = '0;
    reset_model();
    exp_ready = 1'b1;
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    exp_cap   = 4'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    chk("rst_a1", boardData[3:0], 4'h4);
    chk("rst_e1", boardData[19:16], 4'h6);
    chk("rst_e8", boardData[243:240], 4'hE);
    chk("rst_h8", boardData[255:252], 4'hC);
    chk("rst_turn", turn, 1'b0);
    chk("rst_ready", move_ready, 1'b1);

    mv(52, 44);
    chk("wrong_col_err", move_err, 1'b1);
    mv(20, 28);
    chk("empty_err", move_err, 1'b1);
    chk("empty_turn", turn, 1'b0);

    mv(12, 28);
    chk("push_err", move_err, 1'b0);
    chk("push_cap", captured, 4'h0);
    chk("push_28", sq(28), 4'h1);
    chk("push_12", sq(12), 4'h0);
    chk("push_turn", turn, 1'b1);

    mv(62, 36);
    chk("knight_36", sq(36), 4'hA);
    mv(28, 36);
    chk("capt_cap", captured, 4'hA);
    chk("capt_36", sq(36), 4'h1);
    mv(49, 41);
    mv(0, 1);
    chk("friendly_err", move_err, 1'b1);

    mv(36, 52);
    chk("capt2_cap", captured, 4'h9);
    mv(60, 44);
    mv(52, 60);
    chk("promo_w", sq(60), 4'h5);
    mv(41, 8);
    chk("nopromo_b", sq(8), 4'h9);
    mv(0, 16);
    mv(8, 0);
    chk("promo_b", sq(0), 4'hD);
    mv(16, 16);
    chk("same_sq_err", move_err, 1'b1);

    @(posedge clk); #1;
    new_game   = 1'b1;
    move_valid = 1'b1;
    move_from  = 6'd12;
    move_to    = 6'd28;
    exp_ready  = 1'b0;
    @(posedge clk); #1;
    new_game   = 1'b0;
    move_valid = 1'b0;
    reset_model();
    exp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("race_28", sq(28), 4'h0);

    mv(12, 28);
    @(posedge clk); #1;
    move_valid = 1'b1;
    move_from  = 6'd52;
    move_to    = 6'd36;
    @(posedge clk); #1;
    move_valid = 1'b0;
    exp_ready  = 1'b0;
    new_game   = 1'b1;
    @(posedge clk); #1;
    new_game  = 1'b0;
    reset_model();
    exp_ready = 1'b1;
    @(negedge clk);
    chk("abort_ready", move_ready, 1'b1);
    chk("abort_turn", turn, 1'b0);
    chk("abort_28", sq(28), 4'h0);
    repeat (5) @(posedge clk);
    #1 chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
